pc_target_table: RTL and testbench

Programmable branch-target table for the fetch stage. It holds a parametrised number of signed PC offsets and is written at run time through a valid/ready port. Lookups return a registered offset one cycle after the request. A multi-cycle clear sequencer can re-initialise the whole table without a reset. The fetch PC adder consumes `target` as a relative jump; when `target` is 0 the PC holds.

---
 rtl/pc_target_table_pkg.sv | 36 +++
 rtl/pc_target_table.sv | 112 +++++++++++
 tb/tb_pc_target_table.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_target_table_pkg.sv
// pc_target_pkg: shared types and constants for pc_target_table.
//   state_t            - sequencer states (IDLE, CLEAR)
//   DEF_OFF0..DEF_OFF2 - default offsets for entries 0..2 (signed, 32-bit)
//   init_val(idx, d)   - reset/clear value of entry idx, truncated to d bits.
//                        The defaults are present only when the build defines
//                        PC_TARGET_DEFAULTS_EN; otherwise every entry is 0.
package pc_target_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam int DEF_OFF0 = -5;
    localparam int DEF_OFF1 = 20;
    localparam int DEF_OFF2 = -1;

    // Returns the init value in the low d bits (upper bits zero); callers
    // size-cast the result to their offset width.
    function automatic logic [31:0] init_val(input int unsigned idx, input int unsigned d);
        logic [31:0] v;
        logic [31:0] mask;
        v = '0;
`ifdef PC_TARGET_DEFAULTS_EN
        case (idx)
            0:       v = DEF_OFF0;
            1:       v = DEF_OFF1;
            2:       v = DEF_OFF2;
            default: v = '0;
        endcase
`endif
        mask = (d >= 32) ? '1 : ((32'd1 << d) - 32'd1);
        return v & mask;
    endfunction

endpackage

// File: rtl/pc_target_table.sv
// pc_target_table: programmable branch-target table for the fetch stage.
// Holds DEPTH signed D-bit PC offsets, written through a valid/ready port and
// read by a registered one-cycle lookup. A clear sequencer rewrites every entry
// with its init value over DEPTH cycles without a reset.
// Build option: PC_TARGET_DEFAULTS_EN preloads entries 0..2 with -5/20/-1.
// Ports:
//   clk, reset          - clock, async active-high reset
//   lu_valid/lu_addr    - lookup request and index
//   branch              - branch taken, qualifies the lookup
//   target/tgt_valid/hit- registered lookup result
//   wr_valid/wr_ready/wr_addr/wr_data - write port (ready is combinational)
//   clr_req/busy        - start clear / clear in progress
module pc_target_table
    import pc_target_pkg::*;
#(
    parameter int D     = 10,
    parameter int A     = 8,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         lu_valid,
    input  logic [A-1:0] lu_addr,
    input  logic         branch,
    output logic [D-1:0] target,
    output logic         tgt_valid,
    output logic         hit,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         clr_req,
    output logic         busy
);

    state_t       state;
    logic [A:0]   clr_ptr;
    logic [D-1:0] entry [DEPTH];

    logic         wr_accept;
    logic         wr_in_range;
    logic         lu_in_range;
    logic         bypass;
    logic         lu_hit;
    logic [D-1:0] lu_val;

    assign busy     = (state == CLEAR);
    assign wr_ready = (state == IDLE) && !clr_req;

    always_comb begin
        wr_accept   = wr_valid && wr_ready;
        // Compare at A+1 bits so DEPTH == 2**A does not wrap.
        wr_in_range = {1'b0, wr_addr} < (A+1)'(DEPTH);
        lu_in_range = {1'b0, lu_addr} < (A+1)'(DEPTH);
        bypass      = wr_accept && (wr_addr == lu_addr);
        lu_val      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (lu_addr == A'(i))
                lu_val = entry[i];
        end
        // Same-cycle write to the looked-up index is returned directly.
        if (bypass)
            lu_val = wr_data;
        lu_hit = lu_valid && branch && lu_in_range && !busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clr_ptr   <= '0;
            target    <= '0;
            tgt_valid <= 1'b0;
            hit       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == (A+1)'(DEPTH - 1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            tgt_valid <= lu_valid;
            hit       <= lu_hit;
            target    <= lu_hit ? lu_val : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                entry[i] <= D'(init_val(i, D));
        end else if (busy) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clr_ptr == (A+1)'(i))
                    entry[i] <= D'(init_val(i, D));
            end
        end else if (wr_accept && wr_in_range) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_addr == A'(i))
                    entry[i] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_pc_target_table.sv
// tb_pc_target_table: self-checking bench for pc_target_table.
// Works with PC_TARGET_DEFAULTS_EN defined or undefined.
module tb_pc_target_table;

    localparam int D     = 10;
    localparam int A     = 8;
    localparam int DEPTH = 32;

`ifdef PC_TARGET_DEFAULTS_EN
    localparam int I0 = -5;
    localparam int I1 = 20;
    localparam int I2 = -1;
`else
    localparam int I0 = 0;
    localparam int I1 = 0;
    localparam int I2 = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         lu_valid;
    logic [A-1:0] lu_addr;
    logic         branch;
    logic [D-1:0] target;
    logic         tgt_valid;
    logic         hit;
    logic         wr_valid;
    logic         wr_ready;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         clr_req;
    logic         busy;

    pc_target_table #(.D(D), .A(A), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .branch(branch),
        .target(target), .tgt_valid(tgt_valid), .hit(hit),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: table contents plus remaining clear cycles.
    int m [DEPTH];
    int clr_left;

    int last_busy, last_ready, last_target, last_hit;

    function automatic int tb_init(input int i);
        case (i)
            0:       return I0;
            1:       return I1;
            2:       return I2;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = tb_init(i);
        clr_left = 0;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // check the registered lookup result after the edge.
    task automatic step(input int lv, input int la, input int br, input int wv,
                        input int wa, input int wd, input int cr);
        int busy_m, rdy, acc, eh, et;
        logic [D-1:0] wdl;
        @(negedge clk);
        wdl      = D'(wd);
        lu_valid = lv[0];
        lu_addr  = A'(la);
        branch   = br[0];
        wr_valid = wv[0];
        wr_addr  = A'(wa);
        wr_data  = wdl;
        clr_req  = cr[0];
        #1;
        busy_m = (clr_left > 0) ? 1 : 0;
        rdy    = (!busy_m && !cr[0]) ? 1 : 0;
        chk("busy", int'(busy), busy_m);
        chk("wr_ready", int'(wr_ready), rdy);
        last_busy  = int'(busy);
        last_ready = int'(wr_ready);
        acc = (wv[0] && rdy) ? 1 : 0;
        eh  = (lv[0] && br[0] && la < DEPTH && !busy_m) ? 1 : 0;
        et  = 0;
        if (eh) et = (acc && wa == la) ? int'($signed(wdl)) : m[la];
        if (busy_m) begin
            m[DEPTH - clr_left] = tb_init(DEPTH - clr_left);
            clr_left--;
        end else if (cr[0]) begin
            clr_left = DEPTH;
        end
        if (acc && wa < DEPTH) m[wa] = int'($signed(wdl));
        @(posedge clk);
        #1;
        chk("tgt_valid", int'(tgt_valid), lv[0] ? 1 : 0);
        chk("hit", int'(hit), eh);
        chk("target", int'($signed(target)), et);
        last_target = int'($signed(target));
        last_hit    = int'(hit);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (clr_left > 0 && n < DEPTH + 8) begin
            step(0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        chk(name, clr_left, 0);
    endtask

    typedef struct {
        int la;
        int br;
        int exp_t;
        int exp_h;
    } vec_t;

    vec_t vec [6];

    initial begin
        int n;
        vec[0] = '{0, 1, I0, 1};
        vec[1] = '{1, 1, I1, 1};
        vec[2] = '{2, 1, I2, 1};
        vec[3] = '{3, 1, 0, 1};
        vec[4] = '{7, 0, 0, 0};
        vec[5] = '{DEPTH, 1, 0, 0};

        reset = 1'b1;
        lu_valid = 0; lu_addr = '0; branch = 0;
        wr_valid = 0; wr_addr = '0; wr_data = '0; clr_req = 0;
        model_reset();
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_tgt_valid", int'(tgt_valid), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_target", int'($signed(target)), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // Reset-state lookups, range and branch qualification.
        for (int i = 0; i < 6; i++) begin
            step(1, vec[i].la, vec[i].br, 0, 0, 0, 0);
            chk("vec_target", last_target, vec[i].exp_t);
            chk("vec_hit", last_hit, vec[i].exp_h);
            chk("vec_tgt_valid", int'(tgt_valid), 1);
        end

        // Write-through bypass, then read from storage.
        step(1, 5, 1, 1, 5, 13, 0);
        chk("bypass_13", last_target, 13);
        step(1, 5, 1, 0, 0, 0, 0);
        chk("stored_13", last_target, 13);

        // Write 9, then a full clear.
        step(0, 0, 0, 1, 5, 9, 0);
        step(1, 5, 1, 0, 0, 0, 0);
        chk("stored_9", last_target, 9);
        step(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        for (int k = 0; k < DEPTH + 8; k++) begin
            step(1, 5, 1, 0, 0, 0, 0);
            if (last_busy != 0) begin
                n++;
                chk("clr_wr_ready", last_ready, 0);
                chk("clr_hit", last_hit, 0);
                chk("clr_target", last_target, 0);
            end else if (n > 0) begin
                break;
            end
        end
        chk("clr_len", n, DEPTH);
        chk("post_clr_e5", last_target, 0);

        // Clear and write in the same cycle: write refused, clear runs.
        step(0, 0, 0, 1, 4, 11, 1);
        chk("clr_wr_refused", last_ready, 0);
        wait_idle("clr2_done");
        step(1, 4, 1, 0, 0, 0, 0);
        chk("e4_unwritten", last_target, 0);

        // Out-of-range write is accepted and dropped.
        step(0, 0, 0, 1, DEPTH + 1, 77, 0);
        chk("oor_wr_ready", last_ready, 1);
        for (int i = 0; i < DEPTH; i++) step(1, i, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        chk("e0_after_oor", last_target, I0);

        // Reset in the middle of a clear.
        step(0, 0, 0, 1, 0, 100, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < DEPTH / 2; k++) step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        lu_valid = 0; wr_valid = 0; clr_req = 0;
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("midclr_rst_busy", int'(busy), 0);
        chk("midclr_rst_ready", int'(wr_ready), 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 1, 0, 0, 0, 0);
        chk("midclr_rst_e0", last_target, I0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0) ? 1 : 0,
                 int'($urandom_range(0, DEPTH + 3)),
                 ($urandom_range(0, 4) != 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, DEPTH + 3)),
                 int'($urandom_range(0, (1 << D) - 1)),
                 ($urandom_range(0, 39) == 0) ? 1 : 0);
        end
        wait_idle("rand_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
